// File: rtl/chunked_adder_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// index-width helper.
package chunked_adder_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  // Chunk index needs at least one bit even when there is a single chunk.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_sub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the MSB
// so the top can form the signed-overflow flag on the last chunk.
module chunked_adder_sub_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             carry_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             carry_o,
  output logic             carry_msb_o
);

  logic [CHUNK:0] c;

  assign c[0] = carry_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    chunked_adder_sub_full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (sum_o[i]),
      .c_o (c[i+1])
    );
  end

  assign carry_o     = c[CHUNK];
  assign carry_msb_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder_sub_full_adder.sv
// Single-bit full adder, the building block of the chunk adder.
module chunked_adder_sub_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/chunked_adder_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per cycle with
// a registered carry between chunks.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The input side is ready only in IDLE; the output side holds
// out/carry_out/overflow stable while out_valid is high until out_ready.
module chunked_adder_sub
  import chunked_adder_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output state_e           dbg_state
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("chunked_adder_sub: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             chunk_cout, chunk_cmsb;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunked_adder_sub_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i         (a_chunk),
    .b_i         (b_chunk),
    .carry_i     (carry_q),
    .sum_o       (sum_chunk),
    .carry_o     (chunk_cout),
    .carry_msb_o (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1; a borrow-in cancels the +1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = carry_in ^ sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d = chunk_cout;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            out_d[i*CHUNK +: CHUNK] = sum_chunk;
          end
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chunked_adder_sub.sv
// Scoreboard bench: directed vectors on the 16/4 configuration, plus model
// sweeps on CHUNK=16 and CHUNK=1 instances.
module tb_chunked_adder_sub;
  import chunked_adder_sub_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT signals ----------------
  logic         in_valid_m, in_ready_m, ci_m, sub_m, out_valid_m, out_ready_m, cout_m, ovf_m;
  logic [W-1:0] a_m, b_m, out_m;
  state_e       st_m;
  logic         in_valid_h, in_ready_h, ci_h, sub_h, out_valid_h, out_ready_h, cout_h, ovf_h;
  logic [W-1:0] a_h, b_h, out_h;
  state_e       st_h;
  logic         in_valid_s, in_ready_s, ci_s, sub_s, out_valid_s, out_ready_s, cout_s, ovf_s;
  logic [W-1:0] a_s, b_s, out_s;
  state_e       st_s;

  chunked_adder_sub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .a(a_m), .b(b_m), .carry_in(ci_m), .sub(sub_m), .out_valid(out_valid_m),
    .out_ready(out_ready_m), .out(out_m), .carry_out(cout_m), .overflow(ovf_m),
    .dbg_state(st_m)
  );

  chunked_adder_sub #(.WIDTH(W), .CHUNK(16)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .carry_in(ci_h), .sub(sub_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .out(out_h), .carry_out(cout_h), .overflow(ovf_h),
    .dbg_state(st_h)
  );

  chunked_adder_sub #(.WIDTH(W), .CHUNK(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .carry_in(ci_s), .sub(sub_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .out(out_s), .carry_out(cout_s), .overflow(ovf_s),
    .dbg_state(st_s)
  );

  // ---------------- scoreboard ----------------
  // Expected entries are {carry_out, overflow, out}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_h_q[$];
  logic [W+1:0] exp_s_q[$];
  int acc_q[$];
  int acc_h_q[$];
  int acc_s_q[$];

  function automatic void chk(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Independent reference: wide sum plus sign-based overflow rule.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rci, input logic rsub);
    logic [W:0]   t;
    logic [W-1:0] bx;
    logic         cin, v;
    bx  = rsub ? ~rb : rb;
    cin = rsub ? ~rci : rci;
    t   = {1'b0, ra} + {1'b0, bx} + {{W{1'b0}}, cin};
    if (rsub) v = (ra[W-1] != rb[W-1]) && (t[W-1] != ra[W-1]);
    else      v = (ra[W-1] == rb[W-1]) && (t[W-1] != ra[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  // ---------------- monitors ----------------
  // Latency counts rising edges from the accept edge through the edge that
  // raises out_valid, both inclusive.
  logic pv_m = 1'b0, pv_h = 1'b0, pv_s = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) pv_m <= 1'b0;
    else begin
      if (out_valid_m && !pv_m) begin
        if (acc_q.size() == 0) fail("m_unexpected_valid");
        else chk_int("m_latency", cyc - acc_q.pop_front() + 1, 5);
      end
      if (out_valid_m) begin
        if (exp_q.size() == 0) fail("m_result_without_expect");
        else if (out_ready_m) chk("m_result", {cout_m, ovf_m, out_m}, exp_q.pop_front());
        else chk("m_hold", {cout_m, ovf_m, out_m}, exp_q[0]);
      end
      pv_m <= out_valid_m;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pv_h <= 1'b0;
    else begin
      if (out_valid_h && !pv_h) begin
        if (acc_h_q.size() == 0) fail("h_unexpected_valid");
        else chk_int("h_latency", cyc - acc_h_q.pop_front() + 1, 2);
      end
      if (out_valid_h && out_ready_h) begin
        if (exp_h_q.size() == 0) fail("h_result_without_expect");
        else chk("h_result", {cout_h, ovf_h, out_h}, exp_h_q.pop_front());
      end
      pv_h <= out_valid_h;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pv_s <= 1'b0;
    else begin
      if (out_valid_s && !pv_s) begin
        if (acc_s_q.size() == 0) fail("s_unexpected_valid");
        else chk_int("s_latency", cyc - acc_s_q.pop_front() + 1, 17);
      end
      if (out_valid_s && out_ready_s) begin
        if (exp_s_q.size() == 0) fail("s_result_without_expect");
        else chk("s_result", {cout_s, ovf_s, out_s}, exp_s_q.pop_front());
      end
      pv_s <= out_valid_s;
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                       input logic tsub, input logic [W+1:0] texp);
    int n = 0;
    @(negedge clk);
    while (!in_ready_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_m) begin
      fail("m_in_ready_timeout");
      return;
    end
    in_valid_m = 1'b1; a_m = ta; b_m = tb; ci_m = tci; sub_m = tsub;
    @(posedge clk);
    #1;
    exp_q.push_back(texp);
    acc_q.push_back(cyc);
    in_valid_m = 1'b0;
  endtask

  task automatic sweep_h(input int nops);
    for (int k = 0; k < nops; k++) begin
      int n = 0;
      logic [W-1:0] ra, rb;
      logic rci, rsub;
      ra = W'($urandom_range(0, 65535)); rb = W'($urandom_range(0, 65535));
      rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!in_ready_h && n < 200) begin @(negedge clk); n++; end
      if (!in_ready_h) begin fail("h_in_ready_timeout"); return; end
      in_valid_h = 1'b1; a_h = ra; b_h = rb; ci_h = rci; sub_h = rsub;
      @(posedge clk);
      #1;
      exp_h_q.push_back(ref_model(ra, rb, rci, rsub));
      acc_h_q.push_back(cyc);
      in_valid_h = 1'b0;
    end
  endtask

  task automatic sweep_s(input int nops);
    for (int k = 0; k < nops; k++) begin
      int n = 0;
      logic [W-1:0] ra, rb;
      logic rci, rsub;
      ra = W'($urandom_range(0, 65535)); rb = W'($urandom_range(0, 65535));
      rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!in_ready_s && n < 200) begin @(negedge clk); n++; end
      if (!in_ready_s) begin fail("s_in_ready_timeout"); return; end
      in_valid_s = 1'b1; a_s = ra; b_s = rb; ci_s = rci; sub_s = rsub;
      @(posedge clk);
      #1;
      exp_s_q.push_back(ref_model(ra, rb, rci, rsub));
      acc_s_q.push_back(cyc);
      in_valid_s = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() + exp_h_q.size() + exp_s_q.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if ((exp_q.size() + exp_h_q.size() + exp_s_q.size()) != 0) begin
      fail("drain_timeout");
      exp_q.delete(); exp_h_q.delete(); exp_s_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    in_valid_m = 0; a_m = '0; b_m = '0; ci_m = 0; sub_m = 0; out_ready_m = 1;
    in_valid_h = 0; a_h = '0; b_h = '0; ci_h = 0; sub_h = 0; out_ready_h = 1;
    in_valid_s = 0; a_s = '0; b_s = '0; ci_s = 0; sub_s = 0; out_ready_s = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {cout_m, ovf_m, out_m}, '0);
    chk_int("reset_in_ready", int'(in_ready_m), 1);
    chk_int("reset_out_valid", int'(out_valid_m), 0);
    chk_int("reset_state", int'(st_m), int'(ST_IDLE));
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors: {carry_out, overflow, out}
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
    issue(16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    issue(16'h0005, 16'h0002, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0002});
    drain();

    // Backpressure in DONE with new operands offered
    out_ready_m = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1010});
    n = 0;
    while (!out_valid_m && n < 50) begin @(negedge clk); n++; end
    if (!out_valid_m) fail("bp_out_valid_timeout");
    in_valid_m = 1'b1; a_m = 16'hAAAA; b_m = 16'h5555; ci_m = 1'b0; sub_m = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_int("bp_in_ready", int'(in_ready_m), 0);
      chk_int("bp_out_valid", int'(out_valid_m), 1);
    end
    @(posedge clk);
    #1;
    in_valid_m = 1'b0;
    out_ready_m = 1'b1;
    @(posedge clk);
    #1;
    chk_int("bp_release_out_valid", int'(out_valid_m), 0);
    chk_int("bp_release_in_ready", int'(in_ready_m), 1);
    issue(16'h0001, 16'h0002, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
    drain();

    // Asynchronous reset during chunk 2 of FFFF+0001
    @(negedge clk);
    in_valid_m = 1'b1; a_m = 16'hFFFF; b_m = 16'h0001; ci_m = 1'b0; sub_m = 1'b0;
    @(posedge clk);
    #1;
    in_valid_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_pre_state", int'(st_m), int'(ST_RUN));
    chk_int("rst_pre_in_ready", int'(in_ready_m), 0);
    rst_n = 1'b0;
    #1;
    chk_int("rst_out_valid", int'(out_valid_m), 0);
    chk_int("rst_in_ready", int'(in_ready_m), 1);
    chk("rst_outputs", {cout_m, ovf_m, out_m}, '0);
    chk_int("rst_state", int'(st_m), int'(ST_IDLE));
    @(negedge clk) rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
    drain();

    // Model sweeps on the single-chunk and bit-serial instances
    fork
      sweep_h(1000);
      sweep_s(1000);
    join
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chunked_adder_sub.md
Name: chunked_adder_sub

Overview:
- Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per cycle, with a registered carry between chunks.
- Valid/ready handshake on both input and output; adds subtract mode and a signed-overflow flag.
- Used where a full-width combinational ripple path is too long; trades latency for area and timing.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per cycle; WIDTH % CHUNK must be 0, else elaboration error.
- NUM_CHUNKS (localparam) = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0 = a+b+carry_in; 1 = a-b-carry_in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- carry_out  output  1  raw carry out of MSB (sub: 1 = no borrow).
- overflow  output  1  signed overflow.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: in_ready=1, out_valid=0, out=0, carry_out=0, overflow=0, FSM=IDLE, chunk index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b XOR {WIDTH{sub}}, and carry register = carry_in ^ sub.
  - Clear chunk index; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add chunk[idx] of latched a and b' with the carry register.
  - Write the sum into out[idx*CHUNK +: CHUNK] and update the carry register.
  - On idx==NUM_CHUNKS-1: also capture carry_out and overflow = carry into MSB XOR carry out of MSB; go to DONE. Otherwise idx+1.
- DONE:
  - out_valid=1; out, carry_out and overflow stay stable.
  - On out_ready: go to IDLE (out_valid=0 next cycle). in_valid while not IDLE is ignored.
- Latency:
  - Accept edge to out_valid high is NUM_CHUNKS+1 cycles.
  - Minimum issue interval is NUM_CHUNKS+2 cycles (out_ready held high).
- Output hold: out keeps its last result after the handshake until the next op starts overwriting chunks. Consumers use it only while out_valid=1.
- Subtract:
  - sub=1, carry_in=0 gives a-b.
  - sub=1, carry_in=1 gives a-b-1.
- Widths:
  - All arithmetic is modulo 2^WIDTH.
  - The carry register is 1 bit; no carry is retained between operations.
- Boundaries:
  - CHUNK==WIDTH is legal: single RUN cycle, latency 2.
  - CHUNK==1 is legal: fully bit-serial.
  - The last chunk's carry is the final carry_out; no wrap of the index beyond NUM_CHUNKS-1.
- Reset mid-operation (RUN or DONE): immediately clear all state and outputs to reset values. The next op after release is unaffected by any stale carry or index.

Decomposition:
- Shared header: FSM state encodings (IDLE/RUN/DONE localparams) and the WIDTH % CHUNK check macro.
- One sub-module, chunk_adder (combinational, CHUNK-bit, built from the existing full_adder in a generate loop).
  - Inputs: a, b, carry_in.
  - Outputs: sum, carry_out, carry into MSB (for overflow).

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- a=0x1234, b=0x1111, ci=0, sub=0 -> out=0x2345, carry_out=0, overflow=0; out_valid exactly 5 cycles after accept.
- a=0xFFFF, b=0x0001, sub=0 -> out=0x0000, carry_out=1, overflow=0 (carry ripples through all 4 chunks); a=0x7FFF, b=0x0001 -> out=0x8000, carry_out=0, overflow=1.
- sub=1: a=0x0005, b=0x0007, ci=0 -> out=0xFFFE, carry_out=0, overflow=0; a=0x8000, b=0x0001, ci=0 -> out=0x7FFF, carry_out=1, overflow=1; a=0x0005, b=0x0002, ci=1 -> out=0x0002, carry_out=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> out/flags stable, in_ready=0, new operands not taken; raise out_ready -> IDLE next cycle, then new op accepted.
- Reset: assert rst_n=0 during RUN chunk 2 of 0xFFFF+0x0001 -> out_valid=0, out=0, in_ready=1 immediately. After release, 0x0001+0x0001 -> out=0x0002, carry_out=0.
- Parameter sweep: CHUNK=16 (latency 2) and CHUNK=1 (latency 17), 1000 random add/sub ops each -> match a reference model on out, carry_out and overflow.
